// File: rtl/fp12_pkg.sv
// Shared constants, field layout and FSM state type for the 12-bit
// {sign, exp[4:0], frac[5:0]} floating-point divider.
package fp12_pkg;

  localparam int unsigned Width = 12;
  localparam int unsigned ExpW  = 5;
  localparam int unsigned FracW = 6;
  localparam int unsigned MantW = 7;
  localparam int unsigned QuotW = 8;
  localparam int          Bias  = 15;

  localparam logic [Width-1:0] SatVal  = 12'b0_11110_110000;
  localparam logic [Width-1:0] ZeroVal = 12'h000;

  // First biased exponent that saturates; 31 would be the reserved encoding.
  localparam logic signed [7:0] ExpSat = 8'sd30;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StDone
  } state_e;

endpackage

// File: rtl/fp12_mant_div.sv
// Iterative restoring divider: quot_o = floor(a_mant_i * 128 / b_mant_i), one quotient bit
// per cycle, done_o pulses for one cycle after the eighth bit has been produced.
module fp12_mant_div
  import fp12_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [MantW-1:0] a_mant_i,
  input  logic [MantW-1:0] b_mant_i,
  output logic [QuotW-1:0] quot_o,
  output logic             done_o
);

  logic [7:0]       rem_q, rem_d, rem_sub;
  logic [MantW-1:0] div_q;
  logic [QuotW-1:0] quot_q;
  logic [3:0]       cnt_q;
  logic             busy_q, done_q;
  logic             ge;

  // Both mantissas carry the hidden 1, so rem < 2*div holds and 8 bits suffice.
  always_comb begin
    ge      = rem_q >= {1'b0, div_q};
    rem_sub = ge ? (rem_q - {1'b0, div_q}) : rem_q;
    rem_d   = {rem_sub[6:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      div_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= {1'b0, a_mant_i};
        div_q  <= b_mant_i;
        quot_q <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        quot_q <= {quot_q[QuotW-2:0], ge};
        rem_q  <= rem_d;
        cnt_q  <= cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign quot_o = quot_q;
  assign done_o = done_q;

endmodule

// File: rtl/floating_point_divider.sv
// 12-bit floating-point divider with valid/ready handshakes; special operands finish one
// cycle after acceptance, normal divisions nine cycles after acceptance.
module floating_point_divider
  import fp12_pkg::*;
#(
  parameter int BIAS = Bias
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [Width-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             dz,
  output logic             ovf,
  output logic             unf
);

  state_e           state_q, state_d;
  logic [Width-1:0] a_q, b_q;
  logic [Width-1:0] result_q, result_d;
  logic             dz_q, dz_d, ovf_q, ovf_d, unf_q, unf_d;
  logic             accept, start;
  logic [QuotW-1:0] quot;
  logic             mant_done;
  logic             sign;
  logic             a_zero, b_zero;
  logic signed [7:0] exp_s;
  logic [FracW-1:0] frac;

  assign accept = (state_q == StIdle) && in_valid;
  assign start  = accept && (a[10:6] != '0) && (b[10:6] != '0);

  fp12_mant_div u_mant_div (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .a_mant_i ({1'b1, a[FracW-1:0]}),
    .b_mant_i ({1'b1, b[FracW-1:0]}),
    .quot_o   (quot),
    .done_o   (mant_done)
  );

  always_comb begin
    sign   = a_q[11] ^ b_q[11];
    a_zero = (a_q[10:6] == '0);
    b_zero = (b_q[10:6] == '0);
    // A quotient below 1.0 (quot[7] clear) costs one extra exponent step.
    exp_s  = $signed({3'b000, a_q[10:6]}) - $signed({3'b000, b_q[10:6]})
           + $signed(8'(BIAS)) - $signed({7'd0, ~quot[7]});
    frac   = quot[7] ? quot[6:1] : quot[5:0];
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StDiv;
      StDiv: begin
        if (b_zero) begin
          state_d  = StDone;
          result_d = {sign, SatVal[10:0]};
          {dz_d, ovf_d, unf_d} = 3'b100;
        end else if (a_zero) begin
          state_d  = StDone;
          result_d = ZeroVal;
          {dz_d, ovf_d, unf_d} = 3'b000;
        end else if (mant_done) begin
          state_d = StDone;
          if (exp_s <= 8'sd0) begin
            result_d = ZeroVal;
            {dz_d, ovf_d, unf_d} = 3'b001;
          end else if (exp_s >= ExpSat) begin
            result_d = {sign, SatVal[10:0]};
            {dz_d, ovf_d, unf_d} = 3'b010;
          end else begin
            result_d = {sign, exp_s[4:0], frac};
            {dz_d, ovf_d, unf_d} = 3'b000;
          end
        end
      end
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= ZeroVal;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      if (accept) begin
        a_q <= a;
        b_q <= b;
      end
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule
